// File: rtl/m_gen_imm_pipe_if.sv
// Bus bundle for the immediate-generation pipe: instruction input side,
// flush, decoded-entry output side and the delivered-entry counter.
interface m_gen_imm_pipe_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    // valid/ready: a transfer happens on a rising edge where valid and ready are
    // both 1; valid never waits for ready, and the payload stays stable while
    // valid=1 and ready=0.
    logic             w_in_valid;
    logic             w_in_ready;
    logic [31:0]      w_ir;
    logic             w_flush;
    logic             w_out_valid;
    logic             w_out_ready;
    logic [XLEN-1:0]  w_imm;
    logic             w_r;
    logic             w_i;
    logic             w_s;
    logic             w_b;
    logic             w_u;
    logic             w_j;
    logic             w_ld;
    logic             w_illegal;
    logic [CNT_W-1:0] w_dec_cnt;

    modport slave (
        input  w_in_valid, w_ir, w_flush, w_out_ready,
        output w_in_ready, w_out_valid, w_imm,
               w_r, w_i, w_s, w_b, w_u, w_j, w_ld, w_illegal, w_dec_cnt
    );

    modport master (
        output w_in_valid, w_ir, w_flush, w_out_ready,
        input  w_in_ready, w_out_valid, w_imm,
               w_r, w_i, w_s, w_b, w_u, w_j, w_ld, w_illegal, w_dec_cnt
    );
endinterface

// File: rtl/m_gen_imm_pipe.sv
// RISC-V immediate/type decoder feeding a 2-entry FIFO; decode happens at
// acceptance and the stored result is presented in acceptance order.
module m_gen_imm_pipe #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic           w_clk,
    input  logic           w_rst_n,
    m_gen_imm_pipe_if.slave bus
);
    localparam bit IS64 = (XLEN == 64);

    // Flag vector layout: {illegal, ld, j, u, b, s, i, r}
    localparam logic [7:0] F_R   = 8'h01;
    localparam logic [7:0] F_I   = 8'h02;
    localparam logic [7:0] F_S   = 8'h04;
    localparam logic [7:0] F_B   = 8'h08;
    localparam logic [7:0] F_U   = 8'h10;
    localparam logic [7:0] F_J   = 8'h20;
    localparam logic [7:0] F_LD  = 8'h40;
    localparam logic [7:0] F_ILL = 8'h80;

    logic [4:0]      w_op;
    logic [7:0]      w_dec_flg;
    logic [XLEN-1:0] w_dec_imm;
    logic            w_out_vld;
    logic            w_acc;
    logic            w_dlv;
    logic [1:0]      w_occ_nxt;

    logic [1:0]       r_occ;
    logic             r_wptr;
    logic             r_rptr;
    logic             r_in_rdy;
    logic [CNT_W-1:0] r_dec_cnt;
    logic [XLEN-1:0]  r_imm_q [2];
    logic [7:0]       r_flg_q [2];

    assign w_op = bus.w_ir[6:2];

    always_comb begin
        w_dec_flg = F_ILL;
        w_dec_imm = '0;
        if (bus.w_ir[1:0] == 2'b11) begin
            case (w_op)
                5'b01100: w_dec_flg = F_R;
                5'b01110: if (IS64) w_dec_flg = F_R;
                5'b00000, 5'b00011, 5'b00100, 5'b11001, 5'b11100: begin
                    w_dec_flg = (w_op == 5'b00000) ? (F_I | F_LD) : F_I;
                    w_dec_imm = XLEN'($signed(bus.w_ir[31:20]));
                end
                5'b00110: if (IS64) begin
                    w_dec_flg = F_I;
                    w_dec_imm = XLEN'($signed(bus.w_ir[31:20]));
                end
                5'b01000: begin
                    w_dec_flg = F_S;
                    w_dec_imm = XLEN'($signed({bus.w_ir[31:25], bus.w_ir[11:7]}));
                end
                5'b11000: begin
                    w_dec_flg = F_B;
                    w_dec_imm = XLEN'($signed({bus.w_ir[31], bus.w_ir[7], bus.w_ir[30:25],
                                               bus.w_ir[11:8], 1'b0}));
                end
                5'b01101, 5'b00101: begin
                    w_dec_flg = F_U;
                    w_dec_imm = XLEN'($signed({bus.w_ir[31:12], 12'b0}));
                end
                5'b11011: begin
                    w_dec_flg = F_J;
                    w_dec_imm = XLEN'($signed({bus.w_ir[31], bus.w_ir[19:12], bus.w_ir[20],
                                               bus.w_ir[30:21], 1'b0}));
                end
                default: ;
            endcase
        end
    end

    // Flush wins over both transfer directions; a flushed delivery is not counted.
    assign w_out_vld = (r_occ != 2'd0);
    assign w_acc     = bus.w_in_valid & r_in_rdy & ~bus.w_flush;
    assign w_dlv     = w_out_vld & bus.w_out_ready;

    always_comb begin
        w_occ_nxt = r_occ;
        if (bus.w_flush) begin
            w_occ_nxt = 2'd0;
        end else if (w_acc && !w_dlv) begin
            w_occ_nxt = r_occ + 2'd1;
        end else if (!w_acc && w_dlv) begin
            w_occ_nxt = r_occ - 2'd1;
        end
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_occ     <= 2'd0;
            r_wptr    <= 1'b0;
            r_rptr    <= 1'b0;
            r_in_rdy  <= 1'b0;
            r_dec_cnt <= '0;
        end else begin
            r_occ    <= w_occ_nxt;
            r_in_rdy <= (w_occ_nxt != 2'd2);
            if (bus.w_flush) begin
                r_wptr <= 1'b0;
                r_rptr <= 1'b0;
            end else begin
                if (w_acc) r_wptr <= ~r_wptr;
                if (w_dlv) r_rptr <= ~r_rptr;
                if (w_dlv) r_dec_cnt <= r_dec_cnt + CNT_W'(1);
            end
        end
    end

    // Payload storage needs no reset: it is only visible while occupancy is nonzero.
    always_ff @(posedge w_clk) begin
        if (w_acc) begin
            r_imm_q[r_wptr] <= w_dec_imm;
            r_flg_q[r_wptr] <= w_dec_flg;
        end
    end

    assign bus.w_in_ready  = r_in_rdy;
    assign bus.w_out_valid = w_out_vld;
    assign bus.w_dec_cnt   = r_dec_cnt;
    assign bus.w_imm       = w_out_vld ? r_imm_q[r_rptr] : '0;
    assign bus.w_r         = w_out_vld & r_flg_q[r_rptr][0];
    assign bus.w_i         = w_out_vld & r_flg_q[r_rptr][1];
    assign bus.w_s         = w_out_vld & r_flg_q[r_rptr][2];
    assign bus.w_b         = w_out_vld & r_flg_q[r_rptr][3];
    assign bus.w_u         = w_out_vld & r_flg_q[r_rptr][4];
    assign bus.w_j         = w_out_vld & r_flg_q[r_rptr][5];
    assign bus.w_ld        = w_out_vld & r_flg_q[r_rptr][6];
    assign bus.w_illegal   = w_out_vld & r_flg_q[r_rptr][7];
endmodule

// File: tb/tb_m_gen_imm_pipe.sv
// Directed bench for m_gen_imm_pipe: a 32-bit/16-bit-counter instance and a
// 64-bit/4-bit-counter instance share one stimulus stream.
module tb_m_gen_imm_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] ir;
    logic        flush;
    logic        out_ready;

    int n_checks = 0;
    int n_errors = 0;
    int exp_cnt  = 0;

    m_gen_imm_pipe_if #(.XLEN(32), .CNT_W(16)) ifa ();
    m_gen_imm_pipe_if #(.XLEN(64), .CNT_W(4))  ifb ();

    assign ifa.w_in_valid  = in_valid;
    assign ifa.w_ir        = ir;
    assign ifa.w_flush     = flush;
    assign ifa.w_out_ready = out_ready;
    assign ifb.w_in_valid  = in_valid;
    assign ifb.w_ir        = ir;
    assign ifb.w_flush     = flush;
    assign ifb.w_out_ready = out_ready;

    m_gen_imm_pipe #(.XLEN(32), .CNT_W(16)) u_dut_a (.w_clk(clk), .w_rst_n(rst_n), .bus(ifa));
    m_gen_imm_pipe #(.XLEN(64), .CNT_W(4))  u_dut_b (.w_clk(clk), .w_rst_n(rst_n), .bus(ifb));

    logic [7:0] a_flg;
    logic [7:0] b_flg;
    assign a_flg = {ifa.w_illegal, ifa.w_ld, ifa.w_j, ifa.w_u, ifa.w_b, ifa.w_s, ifa.w_i, ifa.w_r};
    assign b_flg = {ifb.w_illegal, ifb.w_ld, ifb.w_j, ifb.w_u, ifb.w_b, ifb.w_s, ifb.w_i, ifb.w_r};

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // checker
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_head(input string tag, input logic [7:0] fa, input logic [63:0] ia,
                              input logic [7:0] fb, input logic [63:0] ib);
        check_eq({tag, " a_vld"}, 64'(ifa.w_out_valid), 64'(fa != 8'h00));
        check_eq({tag, " a_flg"}, 64'(a_flg), 64'(fa));
        check_eq({tag, " a_imm"}, 64'(ifa.w_imm), ia);
        check_eq({tag, " b_flg"}, 64'(b_flg), 64'(fb));
        check_eq({tag, " b_imm"}, ifb.w_imm, ib);
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, " a_vld"}, 64'(ifa.w_out_valid), 64'd0);
        check_eq({tag, " a_flg"}, 64'(a_flg), 64'd0);
        check_eq({tag, " a_imm"}, 64'(ifa.w_imm), 64'd0);
        check_eq({tag, " b_vld"}, 64'(ifb.w_out_valid), 64'd0);
        check_eq({tag, " b_imm"}, ifb.w_imm, 64'd0);
    endtask

    task automatic check_cnt(input string tag);
        check_eq({tag, " a_cnt"}, 64'(ifa.w_dec_cnt), 64'(exp_cnt % 65536));
        check_eq({tag, " b_cnt"}, 64'(ifb.w_dec_cnt), 64'(exp_cnt % 16));
    endtask

    // drivers
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] v);
        in_valid = 1'b1;
        ir       = v;
        cyc();
    endtask

    // Flag codes {illegal, ld, j, u, b, s, i, r}
    logic [31:0] vec_ir  [12];
    logic [7:0]  vec_fa  [12];
    logic [31:0] vec_ia  [12];
    logic [7:0]  vec_fb  [12];
    logic [63:0] vec_ib  [12];

    initial begin
        vec_ir = '{32'h00500113, 32'hFE112E23, 32'h00000463, 32'h80001063,
                   32'hFFDFF0EF, 32'h002081B3, 32'h00000000, 32'h0000007F,
                   32'hFFF12083, 32'h80000017, 32'h0000003B, 32'hFFF0009B};
        vec_fa = '{8'h02, 8'h04, 8'h08, 8'h08, 8'h20, 8'h01, 8'h80, 8'h80,
                   8'h42, 8'h10, 8'h80, 8'h80};
        vec_ia = '{32'h00000005, 32'hFFFFFFFC, 32'h00000008, 32'hFFFFF000,
                   32'hFFFFFFFC, 32'h00000000, 32'h00000000, 32'h00000000,
                   32'hFFFFFFFF, 32'h80000000, 32'h00000000, 32'h00000000};
        vec_fb = '{8'h02, 8'h04, 8'h08, 8'h08, 8'h20, 8'h01, 8'h80, 8'h80,
                   8'h42, 8'h10, 8'h01, 8'h02};
        vec_ib = '{64'h5, 64'hFFFFFFFFFFFFFFFC, 64'h8, 64'hFFFFFFFFFFFFF000,
                   64'hFFFFFFFFFFFFFFFC, 64'h0, 64'h0, 64'h0,
                   64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFF80000000, 64'h0, 64'hFFFFFFFFFFFFFFFF};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        ir        = 32'h0;
        flush     = 1'b0;
        out_ready = 1'b0;

        // reset values while held in reset
        #3;
        check_idle("rst");
        check_eq("rst a_in_rdy", 64'(ifa.w_in_ready), 64'd0);
        check_cnt("rst");
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        check_eq("rel a_in_rdy", 64'(ifa.w_in_ready), 64'd1);
        check_eq("rel b_in_rdy", 64'(ifb.w_in_ready), 64'd1);

        // single addi x1,x0,-1 with consumer ready
        out_ready = 1'b1;
        push(32'hFFF00093);
        in_valid = 1'b0;
        check_head("addi", 8'h02, 64'hFFFFFFFF, 8'h02, 64'hFFFFFFFFFFFFFFFF);
        cyc();
        exp_cnt = 1;
        check_cnt("addi");
        check_idle("addi drain");

        // two back-to-back lui
        push(32'h80000037);
        ir = 32'h12345037;
        check_head("lui0", 8'h10, 64'h80000000, 8'h10, 64'hFFFFFFFF80000000);
        cyc();
        in_valid = 1'b0;
        check_head("lui1", 8'h10, 64'h12345000, 8'h10, 64'h0000000012345000);
        cyc();
        exp_cnt = 3;
        check_cnt("lui");

        // decode table, streamed at one entry per cycle
        for (int k = 0; k < 12; k++) begin
            push(vec_ir[k]);
            check_head($sformatf("vec%0d", k), vec_fa[k], 64'(vec_ia[k]), vec_fb[k], vec_ib[k]);
        end
        in_valid = 1'b0;
        cyc();
        exp_cnt += 12;
        check_cnt("vec");
        check_idle("vec drain");

        // backpressure: three offered, two buffered, in-order release
        out_ready = 1'b0;
        push(32'h00500113);
        check_eq("bp1 a_in_rdy", 64'(ifa.w_in_ready), 64'd1);
        push(32'hFE112E23);
        check_eq("bp2 a_in_rdy", 64'(ifa.w_in_ready), 64'd0);
        ir = 32'h00000463;
        cyc();
        check_eq("bp3 a_in_rdy", 64'(ifa.w_in_ready), 64'd0);
        check_head("bp hold", 8'h02, 64'h5, 8'h02, 64'h5);
        out_ready = 1'b1;
        cyc();
        check_eq("bp rel a_in_rdy", 64'(ifa.w_in_ready), 64'd1);
        check_head("bp rel1", 8'h04, 64'hFFFFFFFC, 8'h04, 64'hFFFFFFFFFFFFFFFC);
        cyc();
        in_valid = 1'b0;
        check_head("bp rel2", 8'h08, 64'h8, 8'h08, 64'h8);
        cyc();
        exp_cnt += 3;
        check_cnt("bp");
        check_idle("bp drain");

        // flush with two buffered and a same-cycle input
        out_ready = 1'b0;
        push(32'h00500113);
        push(32'hFE112E23);
        flush     = 1'b1;
        ir        = 32'h00000463;
        out_ready = 1'b1;
        cyc();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_idle("flush");
        check_eq("flush a_in_rdy", 64'(ifa.w_in_ready), 64'd1);
        check_cnt("flush");
        cyc();
        check_idle("flush after");

        // counter wrap: 17 deliveries from reset
        rst_n = 1'b0;
        #2;
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        exp_cnt = 0;
        check_cnt("rst2");
        for (int k = 0; k < 17; k++) push(32'h00100093);
        in_valid = 1'b0;
        cyc();
        exp_cnt = 17;
        check_cnt("wrap");
        check_eq("wrap b_cnt1", 64'(ifb.w_dec_cnt), 64'd1);

        // asynchronous reset mid-stream discards buffered entries
        out_ready = 1'b0;
        push(32'h00500113);
        push(32'hFE112E23);
        ir = 32'h00000463;
        #3;
        rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        check_idle("async rst");
        check_eq("async a_in_rdy", 64'(ifa.w_in_ready), 64'd0);
        check_cnt("async rst");
        @(negedge clk);
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc();
        check_eq("post rst a_in_rdy", 64'(ifa.w_in_ready), 64'd1);
        check_idle("post rst");
        cyc();
        check_idle("post rst2");
        check_cnt("post rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/m_gen_imm_pipe.md
M_GEN_IMM_PIPE -- requirements
Module: m_gen_imm_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, immediate/data width; legal values 32 and 64.
REQ-002 SHALL have parameter CNT_W, default 16, width of the decoded-instruction counter.
REQ-003 SHALL have port w_clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port w_rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port w_in_valid, input, 1: w_ir is valid.
REQ-006 SHALL have port w_in_ready, output, 1: the block can accept an instruction.
REQ-007 SHALL have port w_ir, input, 32: instruction word.
REQ-008 SHALL have port w_flush, input, 1: discard all buffered entries.
REQ-009 SHALL have port w_out_valid, output, 1: the decoded entry is valid.
REQ-010 SHALL have port w_out_ready, input, 1: the consumer accepts the entry.
REQ-011 SHALL have port w_imm, output, XLEN: decoded sign-extended immediate.
REQ-012 SHALL have ports w_r, w_i, w_s, w_b, w_u, w_j, w_ld, w_illegal, output, 1 each: type flags.
REQ-013 SHALL have port w_dec_cnt, output, CNT_W: count of entries delivered.

Function
REQ-014 SHALL accept an instruction on a cycle where w_in_valid and w_in_ready are both 1 and w_flush is 0.
REQ-015 SHALL deliver an entry on a cycle where w_out_valid and w_out_ready are both 1.
REQ-016 SHALL buffer up to 2 entries in a FIFO and deliver them in acceptance order.
REQ-017 SHALL drive w_in_ready from registered occupancy: 1 iff the buffer holds fewer than 2 entries.
REQ-018 SHALL assert w_out_valid the cycle after an accept into an empty buffer; latency is 1 cycle.
REQ-019 SHALL leave occupancy unchanged on a simultaneous accept and deliver, with occupancy at 1.
REQ-020 SHALL hold w_imm and all flags stable while w_out_valid=1 and w_out_ready=0.
REQ-021 SHALL, on w_flush=1, set occupancy to 0 at the next edge and drop any same-cycle input; flush has priority over accept and deliver.
REQ-022 SHALL not count an entry in w_dec_cnt when it is delivered in the same cycle as w_flush=1.
REQ-023 SHALL decode the instruction type from w_ir[6:2] at acceptance and store the result with the entry.
  - R type: 01100; also 01110 when XLEN=64.
  - I type: 00000, 00011, 00100, 11001, 11100; also 00110 when XLEN=64.
  - S type: 01000.
  - B type: 11000.
  - U type: 01101, 00101.
  - J type: 11011.
REQ-024 SHALL set w_ld=1 iff w_ir[6:2]=00000.
REQ-025 SHALL set w_illegal=1, all type flags to 0 and w_imm to 0 when w_ir[1:0]!=2'b11 or the opcode is not listed in REQ-023.
REQ-026 SHALL keep the flags w_r..w_j, w_illegal one-hot at all times.
REQ-027 SHALL form the immediate as follows, sign-extended from w_ir[31] to XLEN:
  - I: w_ir[31:20].
  - S: {w_ir[31:25], w_ir[11:7]}.
  - B: {w_ir[31], w_ir[7], w_ir[30:25], w_ir[11:8], 0}.
  - U: {w_ir[31:12], 12'b0}.
  - J: {w_ir[31], w_ir[19:12], w_ir[20], w_ir[30:21], 0}.
  - R: 0.
REQ-028 SHALL increment w_dec_cnt by 1 per delivered entry, wrapping from 2^CNT_W-1 to 0.
REQ-029 SHALL drive w_imm and all flags to 0 whenever w_out_valid=0.

Reset
REQ-030 SHALL, while w_rst_n=0, immediately force occupancy to 0 and the outputs to these values: w_out_valid=0, w_in_ready=0, w_imm=0, all flags 0, w_dec_cnt=0.
REQ-031 SHALL assert w_in_ready=1 on the first edge after w_rst_n deasserts.
REQ-032 SHALL, when reset asserts mid-operation, discard buffered entries without delivering them.

Verification
REQ-033 Bench SHALL cover: accept 0xFFF00093 with w_out_ready=1 -> next cycle w_out_valid=1, w_i=1, w_imm=0xFFFFFFFF, w_dec_cnt=1.
REQ-034 Bench SHALL cover, with XLEN=64: accept 0x80000037, then 0x12345037 -> w_u=1, w_imm=0xFFFFFFFF80000000, then 0x0000000012345000.
REQ-035 Bench SHALL cover: hold w_out_ready=0 and offer 3 instructions -> w_in_ready=0 after 2 accepts; on release, delivery occurs in order with 1 entry per cycle.
REQ-036 Bench SHALL cover: with 2 entries buffered, w_flush=1 alongside w_in_valid=1 -> next cycle w_out_valid=0, w_in_ready=1, w_dec_cnt unchanged.
REQ-037 Bench SHALL cover: accept 0x00000000 and 0x0000007F -> w_illegal=1, w_imm=0, all other flags 0.
REQ-038 Bench SHALL cover: with CNT_W=4, deliver 17 entries -> w_dec_cnt reads 1; asserting w_rst_n=0 mid-stream -> outputs 0 without waiting for a clock edge.
